// File: rtl/key_action_ctrl_if.sv
// Decoded PS/2 key event bus: {extended, scan code} plus
// one-cycle make (press) and brakk (release) strobes.
interface key_action_ctrl_if;
  logic [8:0] keyCode;
  logic       make;
  logic       brakk;

  modport master (
    output keyCode,
    output make,
    output brakk
  );

  modport slave (
    input keyCode,
    input make,
    input brakk
  );
endinterface

// File: rtl/key_action_ctrl.sv
// Key-to-action controller: held keys, last-pressed-wins steering,
// pause toggle, rate-limited fire FSM. KEY_ACTION_AUTO_FIRE_EN = auto-fire.
module key_action_ctrl #(
  parameter logic [8:0]  LEFT_CODE       = 9'h16B,
  parameter logic [8:0]  RIGHT_CODE      = 9'h174,
  parameter logic [8:0]  FIRE_CODE       = 9'h029,
  parameter logic [8:0]  PAUSE_CODE      = 9'h04D,
  parameter logic [23:0] COOLDOWN_CYCLES = 24'd12_500_000
) (
  input  logic              clk,
  input  logic              reset,
  key_action_ctrl_if.slave  kev,
  input  logic              shot_active,
  output logic              move_left,
  output logic              move_right,
  output logic              fire,
  output logic              pause
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_FIRE,
    S_COOL
  } state_e;

  state_e      state_q;
  logic [23:0] cnt_q;
  logic        left_q, right_q, fhold_q, phold_q;
  logic        left_d, right_d, fhold_d, phold_d;
  logic        dir_q, dir_d;
  logic        pause_q, pause_d;
  logic        mvl_q, mvl_d, mvr_q, mvr_d;
  logic        fire_q;
  logic        brk;
  logic        rise_l, rise_r, rise_f, rise_p;

  function automatic logic upd(
    input logic h,
    input logic hit,
    input logic mk,
    input logic br
  );
    if (mk && hit)
      return 1'b1;
    else if (br && hit)
      return 1'b0;
    return h;
  endfunction

  // make wins over a simultaneous brakk
  assign brk = kev.brakk & ~kev.make;

  always_comb begin
    left_d  = upd(left_q,  kev.keyCode == LEFT_CODE,
                  kev.make, brk);
    right_d = upd(right_q, kev.keyCode == RIGHT_CODE,
                  kev.make, brk);
    fhold_d = upd(fhold_q, kev.keyCode == FIRE_CODE,
                  kev.make, brk);
    phold_d = upd(phold_q, kev.keyCode == PAUSE_CODE,
                  kev.make, brk);
    rise_l  = left_d  & ~left_q;
    rise_r  = right_d & ~right_q;
    rise_f  = fhold_d & ~fhold_q;
    rise_p  = phold_d & ~phold_q;
    dir_d   = dir_q;
    if (rise_l)
      dir_d = 1'b0;
    else if (rise_r)
      dir_d = 1'b1;
    pause_d = pause_q ^ rise_p;
    mvl_d   = left_d & (~right_d | ~dir_d) & ~pause_d;
    mvr_d   = right_d & (~left_d | dir_d) & ~pause_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      fhold_q <= 1'b0;
      phold_q <= 1'b0;
      dir_q   <= 1'b0;
      pause_q <= 1'b0;
      mvl_q   <= 1'b0;
      mvr_q   <= 1'b0;
      fire_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
      fhold_q <= fhold_d;
      phold_q <= phold_d;
      dir_q   <= dir_d;
      pause_q <= pause_d;
      mvl_q   <= mvl_d;
      mvr_q   <= mvr_d;
      fire_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise_f)
            state_q <= S_PEND;
        end
        S_PEND: begin
          if (!shot_active && !pause_q) begin
            state_q <= S_FIRE;
            fire_q  <= 1'b1;
          end
        end
        S_FIRE: begin
          cnt_q   <= COOLDOWN_CYCLES - 24'd1;
          state_q <= S_COOL;
        end
        S_COOL: begin
          // the zero-count cycle is itself an unpaused cooldown cycle
          if (!pause_q) begin
            if (cnt_q == 24'd0) begin
`ifdef KEY_ACTION_AUTO_FIRE_EN
              state_q <= fhold_q ? S_PEND : S_IDLE;
`else
              state_q <= S_IDLE;
`endif
            end else begin
              cnt_q <= cnt_q - 24'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign move_left  = mvl_q;
  assign move_right = mvr_q;
  assign fire       = fire_q;
  assign pause      = pause_q;

endmodule

// File: tb/tb_key_action_ctrl.sv
// Directed bench for key_action_ctrl: per-cycle compare against a
// behavioural model plus hand-computed literal expectations.
module tb_key_action_ctrl;

  localparam int C = 5;
`ifdef KEY_ACTION_AUTO_FIRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic shot_active;
  logic move_left, move_right, fire, pause;

  key_action_ctrl_if kif();

  key_action_ctrl #(
    .COOLDOWN_CYCLES(24'd5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .kev         (kif),
    .shot_active (shot_active),
    .move_left   (move_left),
    .move_right  (move_right),
    .fire        (fire),
    .pause       (pause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fire_cnt = 0;
  bit chk_en = 1'b0;
  bit shot = 1'b0;

  // model: 0=left 1=right 2=fire 3=pause
  bit h[4];
  bit last_r;
  bit m_pause;
  bit pend;
  bit fnow;
  int cool;

  task automatic cmp(input string name, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [8:0] c, input bit m,
                            input bit b, input bit s, input bit r);
    int idx;
    bit rise[4];
    bit p0, hf0, nf;
    if (r) begin
      h = '{default: 1'b0};
      last_r = 1'b0; m_pause = 1'b0;
      pend = 1'b0; fnow = 1'b0; cool = 0;
      return;
    end
    rise = '{default: 1'b0};
    idx = (c == 9'h16B) ? 0 : (c == 9'h174) ? 1 :
          (c == 9'h029) ? 2 : (c == 9'h04D) ? 3 : -1;
    p0  = m_pause;
    hf0 = h[2];
    if (idx >= 0) begin
      if (m) begin
        rise[idx] = !h[idx];
        h[idx] = 1'b1;
      end else if (b) begin
        h[idx] = 1'b0;
      end
    end
    if (rise[0]) last_r = 1'b0;
    if (rise[1]) last_r = 1'b1;
    if (rise[3]) m_pause = !m_pause;
    nf = 1'b0;
    if (fnow) begin
      cool = C;
    end else if (cool > 0) begin
      if (!p0) begin
        cool--;
        if (cool == 0 && AUTO && hf0) pend = 1'b1;
      end
    end else if (pend) begin
      if (!s && !p0) begin
        pend = 1'b0;
        nf = 1'b1;
      end
    end else if (rise[2]) begin
      pend = 1'b1;
    end
    fnow = nf;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("move_left", move_left,
          h[0] && (!h[1] || !last_r) && !m_pause);
      cmp("move_right", move_right,
          h[1] && (!h[0] || last_r) && !m_pause);
      cmp("pause", pause, m_pause);
      cmp("fire", fire, fnow);
      if (fire === 1'b1) fire_cnt++;
    end
  end

  task automatic step(input logic [8:0] c, input bit m,
                      input bit b, input bit r);
    kif.keyCode = c;
    kif.make    = m;
    kif.brakk   = b;
    shot_active = shot;
    reset       = r;
    @(posedge clk);
    model_step(c, m, b, shot, r);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(9'h000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mk(input logic [8:0] c);
    step(c, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic br(input logic [8:0] c);
    step(c, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    kif.keyCode = '0; kif.make = 1'b0; kif.brakk = 1'b0;
    shot_active = 1'b0; reset = 1'b1;
    step(9'h000, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(9'h000, 1'b0, 1'b0, 1'b1);
    cmp("rst_left", move_left, 1'b0);
    cmp("rst_right", move_right, 1'b0);
    cmp("rst_fire", fire, 1'b0);
    cmp("rst_pause", pause, 1'b0);
    idle(2);

    // last pressed wins
    mk(9'h16B);
    cmp("lpw_l_only", move_left, 1'b1);
    mk(9'h174);
    cmp("lpw_r_wins", move_right, 1'b1);
    cmp("lpw_l_lost", move_left, 1'b0);
    mk(9'h16B);
    cmp("lpw_rep_r", move_right, 1'b1);
    cmp("lpw_rep_l", move_left, 1'b0);
    br(9'h174);
    cmp("lpw_rel_l", move_left, 1'b1);
    cmp("lpw_rel_r", move_right, 1'b0);
    br(9'h16B);
    idle(2);

    // fire gated by shot_active
    shot = 1'b1;
    fire_cnt = 0;
    mk(9'h029);
    br(9'h029);
    idle(6);
    cmp("gate_nofire", fire_cnt != 0, 1'b0);
    shot = 1'b0;
    idle(1);
    cmp("gate_fire", fire, 1'b1);
    idle(2);
    mk(9'h029);
    br(9'h029);
    idle(12);
    cmp("gate_one", fire_cnt == 1, 1'b1);

    // reset in the middle of cooldown
    mk(9'h16B);
    mk(9'h029);
    idle(1);
    cmp("rst_pre_fire", fire, 1'b1);
    idle(2);
    step(9'h000, 1'b0, 1'b0, 1'b1);
    cmp("mid_rst_left", move_left, 1'b0);
    cmp("mid_rst_fire", fire, 1'b0);
    mk(9'h029);
    cmp("post_rst_p1", fire, 1'b0);
    idle(1);
    cmp("post_rst_p2", fire, 1'b1);
    br(9'h029);
    idle(8);

    // typematic repeats of the space bar
    mk(9'h029);
    fire_cnt = 0;
    for (int i = 0; i < 98; i++) begin
      if (i % 10 == 8) mk(9'h029);
      else idle(1);
    end
    cmp("typematic_cnt", fire_cnt == (AUTO ? 14 : 1), 1'b1);
    br(9'h029);
    idle(12);

    // pause
    mk(9'h16B);
    cmp("p_move_pre", move_left, 1'b1);
    mk(9'h04D);
    cmp("p_on", pause, 1'b1);
    cmp("p_frozen", move_left, 1'b0);
    mk(9'h04D);
    cmp("p_repeat", pause, 1'b1);
    br(9'h04D);
    fire_cnt = 0;
    mk(9'h029);
    br(9'h029);
    idle(5);
    cmp("p_hold_pend", fire_cnt != 0, 1'b0);
    mk(9'h04D);
    cmp("p_off", pause, 1'b0);
    cmp("p_off_nofire", fire, 1'b0);
    br(9'h04D);
    cmp("p_release_fire", fire, 1'b1);
    cmp("p_move_back", move_left, 1'b1);
    idle(8);

    // unmapped key and simultaneous make/brakk
    mk(9'h01C);
    cmp("unm_left", move_left, 1'b1);
    cmp("unm_right", move_right, 1'b0);
    cmp("unm_pause", pause, 1'b0);
    br(9'h16B);
    cmp("rel_left", move_left, 1'b0);
    step(9'h16B, 1'b1, 1'b1, 1'b0);
    cmp("simul_make", move_left, 1'b1);
    br(9'h16B);
    idle(3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
